// File: rtl/sw_result_collector_pkg.sv
// Shared widths for the Smith-Waterman result collector.
// Default field widths match the SmithWaterman core (score width, target
// index width) and define the packed record layout held in the FIFO:
//   { qidx[REC_QIDX_BIT], tidx[MAX_T_NUM_BIT], score[CALC_BIT], tcnt[REC_TCNT_BIT] }
package sw_result_collector_pkg;

   localparam int CALC_BIT      = 16;                 // score width
   localparam int MAX_T_NUM_BIT = 8;                  // target index width
   localparam int REC_QIDX_BIT  = 8;                  // query counter width
   localparam int REC_TCNT_BIT  = MAX_T_NUM_BIT + 1;  // target count reaches 2^MAX_T_NUM_BIT
   localparam int REC_WIDTH     = REC_QIDX_BIT + MAX_T_NUM_BIT + CALC_BIT + REC_TCNT_BIT;

   // Record width for an arbitrary parameterisation of the collector.
   function automatic int rec_width(input int score_w, input int tidx_w, input int qidx_w);
      return qidx_w + tidx_w + score_w + (tidx_w + 1);
   endfunction

endpackage

// File: rtl/sw_rec_fifo.sv
// Synchronous first-word-fall-through FIFO for collector records.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous flush (priority over push/pop)
//   push, din    write request and data; accepted when not full, or when
//                full and a pop happens on the same edge
//   full         occupancy == DEPTH
//   pop          read request; ignored when empty
//   dout         head entry, forced to 0 while empty
//   empty        occupancy == 0
//   level        occupancy, 0..DEPTH
module sw_rec_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   output logic                       full,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push, do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == FULL_CNT);
   assign do_pop  = pop & ~empty;
   // A full FIFO still takes a write when the head leaves on the same edge.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);   // power-of-2 depth: natural wrap
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: contents are only visible through the masked head.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= din;
   end

   assign dout  = empty ? '0 : mem[rd_ptr];
   assign level = cnt;

endmodule

// File: rtl/sw_result_collector.sv
// Collects the SmithWaterman per-target score stream into one summary record
// per query (best target index, best score, target count) and buffers the
// records in a small FWFT FIFO drained by the host with valid/ready.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear_i           synchronous clear of all state (highest priority)
//   valid_i           score beat valid
//   result_i          unsigned score of the current target
//   change_q_i        beat closes the current query (qualified by valid_i)
//   rec_valid_o       FIFO head valid
//   rec_ready_i       host accepts head
//   rec_qidx_o        query number of head record
//   rec_tidx_o        best target index of head record
//   rec_score_o       best score of head record
//   rec_tcnt_o        target count of head record
//   level_o           FIFO occupancy
//   overflow_o        sticky: a record was dropped on a full FIFO
module sw_result_collector
   import sw_result_collector_pkg::*;
#(
   parameter int SCORE_W = CALC_BIT,
   parameter int TIDX_W  = MAX_T_NUM_BIT,
   parameter int QIDX_W  = REC_QIDX_BIT,
   parameter int DEPTH   = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear_i,
   input  logic                      valid_i,
   input  logic [SCORE_W-1:0]        result_i,
   input  logic                      change_q_i,
   output logic                      rec_valid_o,
   input  logic                      rec_ready_i,
   output logic [QIDX_W-1:0]         rec_qidx_o,
   output logic [TIDX_W-1:0]         rec_tidx_o,
   output logic [SCORE_W-1:0]        rec_score_o,
   output logic [TIDX_W:0]           rec_tcnt_o,
   output logic [$clog2(DEPTH):0]    level_o,
   output logic                      overflow_o
);

   localparam int TCNT_W = TIDX_W + 1;
   localparam int REC_W  = rec_width(SCORE_W, TIDX_W, QIDX_W);
   localparam logic [TCNT_W-1:0] T_SAT = TCNT_W'(1) << TIDX_W;

   logic [QIDX_W-1:0]  q_cnt;
   logic [TCNT_W-1:0]  t_cnt, t_cnt_inc;
   logic [SCORE_W-1:0] cur_max, best_max;
   logic [TIDX_W-1:0]  cur_idx, best_idx;
   logic               take, close, pop, drop;
   logic               fifo_full, fifo_empty;
   logic [REC_W-1:0]   rec_din, rec_dout;

   // First target of a query always wins; afterwards only a strictly larger
   // score replaces the best, so ties keep the earliest target.
   assign take      = valid_i & ((t_cnt == '0) | (result_i > cur_max));
   assign best_max  = take ? result_i : cur_max;
   assign best_idx  = take ? t_cnt[TIDX_W-1:0] : cur_idx;
   assign t_cnt_inc = (t_cnt == T_SAT) ? t_cnt : t_cnt + TCNT_W'(1);

   assign close   = valid_i & change_q_i;
   assign pop     = rec_valid_o & rec_ready_i;
   // Drop only when nothing leaves the FIFO on the closing edge.
   assign drop    = close & fifo_full & ~pop;
   assign rec_din = {q_cnt, best_idx, best_max, t_cnt_inc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_cnt      <= '0;
         t_cnt      <= '0;
         cur_max    <= '0;
         cur_idx    <= '0;
         overflow_o <= 1'b0;
      end else if (clear_i) begin
         q_cnt      <= '0;
         t_cnt      <= '0;
         cur_max    <= '0;
         cur_idx    <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (close) begin
            // Tracking restarts even if the record was dropped, so the host
            // sees the lost query as a gap in qidx.
            q_cnt   <= q_cnt + QIDX_W'(1);
            t_cnt   <= '0;
            cur_max <= '0;
            cur_idx <= '0;
         end else if (valid_i) begin
            t_cnt   <= t_cnt_inc;
            cur_max <= best_max;
            cur_idx <= best_idx;
         end
         if (drop) overflow_o <= 1'b1;
      end
   end

   sw_rec_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear_i),
      .push  (close & ~clear_i),
      .din   (rec_din),
      .full  (fifo_full),
      .pop   (pop & ~clear_i),
      .dout  (rec_dout),
      .empty (fifo_empty),
      .level (level_o)
   );

   assign rec_valid_o = ~fifo_empty;
   assign {rec_qidx_o, rec_tidx_o, rec_score_o, rec_tcnt_o} = rec_dout;

endmodule

// File: tb/tb_sw_result_collector.sv
`timescale 1ns/100ps
module tb_sw_result_collector;

   localparam int SCORE_W = 16;
   localparam int TIDX_W  = 4;
   localparam int QIDX_W  = 8;
   localparam int DEPTH   = 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 clear_i = 1'b0;
   logic                 valid_i = 1'b0;
   logic [SCORE_W-1:0]   result_i = '0;
   logic                 change_q_i = 1'b0;
   logic                 rec_valid_o;
   logic                 rec_ready_i = 1'b0;
   logic [QIDX_W-1:0]    rec_qidx_o;
   logic [TIDX_W-1:0]    rec_tidx_o;
   logic [SCORE_W-1:0]   rec_score_o;
   logic [TIDX_W:0]      rec_tcnt_o;
   logic [2:0]           level_o;
   logic                 overflow_o;

   int tests = 0;
   int fails = 0;

   always #1 clk = ~clk;   // 2 ns period

   sw_result_collector #(
      .SCORE_W (SCORE_W), .TIDX_W (TIDX_W), .QIDX_W (QIDX_W), .DEPTH (DEPTH)
   ) dut (
      .clk (clk), .rst_n (rst_n), .clear_i (clear_i), .valid_i (valid_i),
      .result_i (result_i), .change_q_i (change_q_i), .rec_valid_o (rec_valid_o),
      .rec_ready_i (rec_ready_i), .rec_qidx_o (rec_qidx_o), .rec_tidx_o (rec_tidx_o),
      .rec_score_o (rec_score_o), .rec_tcnt_o (rec_tcnt_o), .level_o (level_o),
      .overflow_o (overflow_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: drive one beat, return at the next negedge.
   task automatic beat(input logic [SCORE_W-1:0] s, input logic c);
      valid_i = 1'b1; result_i = s; change_q_i = c;
      @(negedge clk);
      valid_i = 1'b0; change_q_i = 1'b0; result_i = '0;
   endtask

   task automatic pop1();
      rec_ready_i = 1'b1;
      @(negedge clk);
      rec_ready_i = 1'b0;
   endtask

   task automatic clr();
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
   endtask

   task automatic head(input string tag, input int q, input int t, input int s, input int n);
      chk({tag, "_valid"}, 32'(rec_valid_o), 32'd1);
      chk({tag, "_qidx"},  32'(rec_qidx_o),  32'(q));
      chk({tag, "_tidx"},  32'(rec_tidx_o),  32'(t));
      chk({tag, "_score"}, 32'(rec_score_o), 32'(s));
      chk({tag, "_tcnt"},  32'(rec_tcnt_o),  32'(n));
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_valid"}, 32'(rec_valid_o), 32'd0);
      chk({tag, "_qidx"},  32'(rec_qidx_o),  32'd0);
      chk({tag, "_tidx"},  32'(rec_tidx_o),  32'd0);
      chk({tag, "_score"}, 32'(rec_score_o), 32'd0);
      chk({tag, "_tcnt"},  32'(rec_tcnt_o),  32'd0);
      chk({tag, "_level"}, 32'(level_o),     32'd0);
      chk({tag, "_ovf"},   32'(overflow_o),  32'd0);
   endtask

   initial begin
      #3 rst_n = 1'b1;
      @(negedge clk);
      all_zero("reset");

      // 1: scores 5,9,3 -> qidx0 tidx1 score9 tcnt3, visible right after 3rd edge
      beat(16'd5, 1'b0);
      beat(16'd9, 1'b0);
      chk("t1_no_early_valid", 32'(rec_valid_o), 32'd0);
      beat(16'd3, 1'b1);
      head("t1", 0, 1, 9, 3);
      chk("t1_level", 32'(level_o), 32'd1);
      pop1();
      all_zero("t1_drained");

      // change_q without valid is ignored
      change_q_i = 1'b1;
      @(negedge clk);
      change_q_i = 1'b0;
      chk("chg_no_valid_level", 32'(level_o), 32'd0);

      // 2: tie keeps earliest; this is query 1, next is query 2
      beat(16'd7, 1'b0);
      beat(16'd7, 1'b0);
      beat(16'd2, 1'b1);
      head("t2", 1, 0, 7, 3);
      pop1();
      beat(16'd3, 1'b0);
      beat(16'd8, 1'b1);
      head("t2_next", 2, 1, 8, 2);
      pop1();

      // 3: five one-target queries with no drain
      clr();
      for (int i = 0; i < 5; i++) beat(16'(10 + i), 1'b1);
      chk("t3_level", 32'(level_o), 32'd4);
      chk("t3_ovf", 32'(overflow_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         head($sformatf("t3_drain%0d", i), i, 0, 10 + i, 1);
         pop1();
      end
      chk("t3_empty", 32'(level_o), 32'd0);
      chk("t3_ovf_sticky", 32'(overflow_o), 32'd1);
      beat(16'd20, 1'b1);
      head("t3_gap", 5, 0, 20, 1);
      pop1();

      // 4: full FIFO, pop on the same edge as a closing beat
      clr();
      for (int i = 0; i < 4; i++) beat(16'(30 + i), 1'b1);
      chk("t4_full", 32'(level_o), 32'd4);
      rec_ready_i = 1'b1;
      beat(16'd40, 1'b1);
      rec_ready_i = 1'b0;
      chk("t4_level", 32'(level_o), 32'd4);
      chk("t4_ovf", 32'(overflow_o), 32'd0);
      head("t4_head", 1, 0, 31, 1);
      // now drop one and leave 2 records for the clear test
      beat(16'd41, 1'b1);
      chk("t4_drop_ovf", 32'(overflow_o), 32'd1);
      pop1();
      pop1();
      chk("t6_pre_level", 32'(level_o), 32'd2);

      // 6: clear with 2 records and overflow set
      clr();
      chk("t6_level", 32'(level_o), 32'd0);
      chk("t6_ovf", 32'(overflow_o), 32'd0);
      chk("t6_valid", 32'(rec_valid_o), 32'd0);
      beat(16'd6, 1'b1);
      head("t6_q0", 0, 0, 6, 1);

      // 5: async reset mid-query with a record pending
      beat(16'd4, 1'b0);
      beat(16'd8, 1'b0);
      #0.4 rst_n = 1'b0;
      #0.2;
      all_zero("t5_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      beat(16'd1, 1'b1);
      head("t5_after", 0, 0, 1, 1);
      chk("t5_level", 32'(level_o), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
